// File: rtl/ysyx_040066_mem_stage.sv
// Memory stage of the ysyx_040066 core: latches one EX instruction, runs its data-memory
// transaction, waits for the divider, and hands one record to WB. Define MEM_STAGE_FWD_EN for fwd_* ports.
module ysyx_040066_mem_stage #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_ex_result,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [XLEN-1:0]   in_nxtpc,
    input  logic [2:0]        in_mem_op,
    input  logic              in_mem_rd,
    input  logic              in_mem_wr,
    input  logic              in_reg_wr,
    input  logic              in_is_mul,
    input  logic              in_is_div,
    input  logic              in_fence_i,
    input  logic              in_error,
    input  logic [4:0]        in_rd,
    input  logic [XLEN-1:0]   mul_result,
    input  logic [XLEN-1:0]   div_result,
    input  logic              div_valid,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wr,
    output logic [ADDR_W-1:0] req_addr,
    output logic [XLEN-1:0]   req_wdata,
    output logic [XLEN/8-1:0] req_wmask,
    output logic [2:0]        req_size,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_reg_wr,
    output logic              out_error,
    output logic              out_fence_i,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_data,
    output logic [XLEN-1:0]   out_nxtpc
`ifdef MEM_STAGE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    localparam int MASK_W = XLEN / 8;
    localparam int OFF_W  = $clog2(MASK_W);

    typedef enum logic [1:0] {EMPTY, REQ, RESP, RESULT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] ex_result;
        logic [XLEN-1:0] wdata;
        logic [XLEN-1:0] nxtpc;
        logic [2:0]      mem_op;
        logic            mem_rd;
        logic            mem_wr;
        logic            reg_wr;
        logic            is_mul;
        logic            is_div;
        logic            fence_i;
        logic            error;
        logic [4:0]      rd;
    } rec_t;

    state_t          state_q, state_d;
    rec_t            rec_q, rec_d;
    logic [XLEN-1:0] load_q, load_d;
    logic [OFF_W-1:0] off;
    logic            accept;
    logic            retire;

    function automatic logic misaligned(input logic [OFF_W-1:0] o, input logic [1:0] size);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = o[0];
            2'd2:    misaligned = |o[1:0];
            default: misaligned = (XLEN == 32) ? 1'b1 : |o;
        endcase
    endfunction

    function automatic logic [MASK_W-1:0] lane_mask(input logic [OFF_W-1:0] o, input logic [1:0] size);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        lane_mask = MASK_W'(base) << o;
    endfunction

    // Shift the addressed bytes down to bit 0, then truncate and extend to the access size.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                    input logic [OFF_W-1:0] o,
                                                    input logic [2:0] op);
        logic [XLEN-1:0] sh;
        sh = rdata >> {o, 3'b000};
        case (op[1:0])
            2'd0:    load_extend = op[2] ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
            2'd1:    load_extend = op[2] ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
            2'd2:    load_extend = op[2] ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
            default: load_extend = sh;
        endcase
    endfunction

    assign off       = rec_q.ex_result[OFF_W-1:0];
    assign out_valid = (state_q == RESULT) && (!rec_q.is_div || div_valid);
    assign retire    = out_valid && out_ready;
    assign in_ready  = (state_q == EMPTY) || retire;
    assign accept    = in_valid && in_ready;

    assign req_valid = (state_q == REQ);
    assign req_wr    = rec_q.mem_wr;
    assign req_addr  = ADDR_W'(rec_q.ex_result);
    assign req_wdata = rec_q.wdata << {off, 3'b000};
    assign req_wmask = lane_mask(off, rec_q.mem_op[1:0]);
    assign req_size  = {1'b0, rec_q.mem_op[1:0]};

    assign out_reg_wr  = rec_q.reg_wr && !rec_q.error;
    assign out_error   = rec_q.error;
    assign out_fence_i = rec_q.fence_i && !rec_q.error;
    assign out_rd      = rec_q.rd;
    assign out_nxtpc   = rec_q.nxtpc;

    always_comb begin
        out_data = rec_q.ex_result;
        if (rec_q.mem_rd)      out_data = load_q;
        else if (rec_q.is_mul) out_data = mul_result;
        else if (rec_q.is_div) out_data = div_result;
    end

`ifdef MEM_STAGE_FWD_EN
    assign fwd_valid = out_valid && out_reg_wr && (out_rd != 5'd0);
    assign fwd_rd    = out_rd;
    assign fwd_data  = out_data;
`endif

    always_comb begin
        logic mem_acc;
        logic bad;
        state_d = state_q;
        rec_d   = rec_q;
        load_d  = load_q;
        mem_acc = in_mem_rd || in_mem_wr;
        bad     = mem_acc && misaligned(in_ex_result[OFF_W-1:0], in_mem_op[1:0]);
        case (state_q)
            REQ:     if (req_ready) state_d = RESP;
            RESP: begin
                if (resp_valid) begin
                    state_d = RESULT;
                    if (rec_q.mem_rd) load_d = load_extend(resp_rdata, off, rec_q.mem_op);
                end
            end
            RESULT:  if (retire) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        // A new instruction overrides the EMPTY/RESULT transition chosen above.
        if (accept) begin
            rec_d.ex_result = in_ex_result;
            rec_d.wdata     = in_wdata;
            rec_d.nxtpc     = in_nxtpc;
            rec_d.mem_op    = in_mem_op;
            rec_d.mem_rd    = in_mem_rd;
            rec_d.mem_wr    = in_mem_wr;
            rec_d.reg_wr    = in_reg_wr;
            rec_d.is_mul    = in_is_mul;
            rec_d.is_div    = in_is_div;
            rec_d.fence_i   = in_fence_i;
            rec_d.error     = in_error || bad;
            rec_d.rd        = in_rd;
            load_d          = '0;
            state_d         = (mem_acc && !in_error && !bad) ? REQ : RESULT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            rec_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            load_q  <= load_d;
        end
    end

endmodule
